// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache with a miss FSM.
// Read hits are served combinationally; misses and all stores stall the CPU.
module dcache_controller #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned SETS          = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]    cpu_wd_i,
  input  logic                     cpu_re_i,
  input  logic                     cpu_we_i,
  output logic [DATA_WIDTH-1:0]    cpu_rd_o,
  output logic                     stall_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wd_o,
  input  logic [DATA_WIDTH-1:0]    mem_rd_i,
  input  logic                     mem_ack_i,
  output logic [31:0]              hit_cnt_o,
  output logic [31:0]              miss_cnt_o
);

  localparam int unsigned IdxW = $clog2(SETS);
  localparam int unsigned TagW = ADDRESS_WIDTH - IdxW - 2;

  typedef enum logic [1:0] {StIdle, StRdMiss, StWrThru} state_e;

  state_e                  state_q;
  logic [SETS-1:0]         valid_q;
  logic [TagW-1:0]         tag_q  [SETS];
  logic [DATA_WIDTH-1:0]   data_q [SETS];
  logic                    mem_req_q;
  logic                    mem_we_q;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wd_q;
  logic [31:0]             hit_cnt_q;
  logic [31:0]             miss_cnt_q;

  logic [IdxW-1:0] cpu_idx, mem_idx;
  logic [TagW-1:0] cpu_tag, mem_tag;
  logic            is_store, is_load, hit;
  logic [1:0]      unused_addr_lsb;

  assign cpu_idx  = cpu_addr_i[IdxW+1:2];
  assign cpu_tag  = cpu_addr_i[ADDRESS_WIDTH-1:IdxW+2];
  // The refill line is taken from the registered request address.
  assign mem_idx  = mem_addr_q[IdxW+1:2];
  assign mem_tag  = mem_addr_q[ADDRESS_WIDTH-1:IdxW+2];
  assign unused_addr_lsb = cpu_addr_i[1:0];

  assign is_store = cpu_we_i;
  assign is_load  = cpu_re_i & ~cpu_we_i;
  assign hit      = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    stall_o  = 1'b0;
    cpu_rd_o = '0;
    if (!rst_i) begin
      case (state_q)
        StIdle: begin
          if (is_store || (is_load && !hit)) begin
            stall_o = 1'b1;
          end else if (is_load) begin
            cpu_rd_o = data_q[cpu_idx];
          end
        end
        StRdMiss: begin
          if (mem_ack_i) begin
            cpu_rd_o = mem_rd_i;
          end else begin
            stall_o = 1'b1;
          end
        end
        StWrThru: stall_o = ~mem_ack_i;
        default:  stall_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (is_store) begin
            mem_addr_q <= {cpu_addr_i[ADDRESS_WIDTH-1:2], 2'b00};
            mem_wd_q   <= cpu_wd_i;
            mem_we_q   <= 1'b1;
            mem_req_q  <= 1'b1;
            state_q    <= StWrThru;
          end else if (is_load) begin
            if (hit) begin
              hit_cnt_q <= sat_inc(hit_cnt_q);
            end else begin
              mem_addr_q <= {cpu_addr_i[ADDRESS_WIDTH-1:2], 2'b00};
              mem_we_q   <= 1'b0;
              mem_req_q  <= 1'b1;
              miss_cnt_q <= sat_inc(miss_cnt_q);
              state_q    <= StRdMiss;
            end
          end
        end
        StRdMiss: begin
          if (mem_ack_i) begin
            valid_q[mem_idx] <= 1'b1;
            mem_req_q        <= 1'b0;
            state_q          <= StIdle;
          end
        end
        StWrThru: begin
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == StRdMiss && mem_ack_i) begin
        tag_q[mem_idx]  <= mem_tag;
        data_q[mem_idx] <= mem_rd_i;
      end else if (state_q == StIdle && is_store && hit) begin
        data_q[cpu_idx] <= cpu_wd_i;
      end
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_wd_o   = mem_wd_q;
  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: stimulus pushes expected loads and
// memory requests into queues, a negedge monitor pops and compares them.
module tb_dcache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_wd, cpu_rd;
  logic        cpu_re, cpu_we, stall;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [31:0] hit_cnt, miss_cnt;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } req_t;

  logic [31:0] rd_q[$];
  req_t        req_q[$];
  req_t        cur_req;
  bit          req_seen = 1'b0;

  int tests = 0;
  int fails = 0;
  int ack_dly = 0;
  logic [31:0] mem_data = '0;
  int sc;

  always #5 clk = ~clk;

  dcache_controller #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .SETS         (8)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .cpu_addr_i(cpu_addr),
    .cpu_wd_i  (cpu_wd),
    .cpu_re_i  (cpu_re),
    .cpu_we_i  (cpu_we),
    .cpu_rd_o  (cpu_rd),
    .stall_o   (stall),
    .mem_req_o (mem_req),
    .mem_we_o  (mem_we),
    .mem_addr_o(mem_addr),
    .mem_wd_o  (mem_wd),
    .mem_rd_i  (mem_rd),
    .mem_ack_i (mem_ack),
    .hit_cnt_o (hit_cnt),
    .miss_cnt_o(miss_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    req_t r;
    r.we = we;
    r.addr = addr;
    r.wd = wd;
    req_q.push_back(r);
  endtask

  // Memory responder: acks ack_dly cycles after the request is first seen.
  initial begin
    int cnt = 0;
    mem_ack = 1'b0;
    mem_rd  = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req && !mem_ack) begin
        if (cnt == ack_dly) begin
          mem_ack = 1'b1;
          mem_rd  = mem_data;
          cnt     = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_re && !cpu_we && !stall) begin
        if (rd_q.size() == 0) begin
          check("unexpected load served", 32'd1, 32'd0);
        end else begin
          check("cpu_rd", cpu_rd, rd_q.pop_front());
        end
      end
      if (mem_req) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          if (req_q.size() == 0) begin
            check("unexpected mem_req", 32'd1, 32'd0);
            cur_req = '{we: mem_we, addr: mem_addr, wd: mem_wd};
          end else begin
            cur_req = req_q.pop_front();
          end
        end
        check("mem_addr", mem_addr, cur_req.addr);
        check("mem_we", {31'd0, mem_we}, {31'd0, cur_req.we});
        if (cur_req.we) check("mem_wd", mem_wd, cur_req.wd);
      end else begin
        req_seen = 1'b0;
      end
    end else begin
      req_seen = 1'b0;
    end
  end

  task automatic access(input logic re, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input int dly, input logic [31:0] rdata,
                        output int stall_cycles);
    ack_dly  = dly;
    mem_data = rdata;
    @(posedge clk);
    #1;
    cpu_addr = addr;
    cpu_wd   = wd;
    cpu_re   = re;
    cpu_we   = we;
    stall_cycles = 0;
    @(negedge clk);
    while (stall && stall_cycles < 60) begin
      stall_cycles++;
      @(negedge clk);
    end
    if (stall) check("access timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    cpu_re = 1'b0;
    cpu_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cpu_addr = '0;
    cpu_wd = '0;
    cpu_re = 1'b0;
    cpu_we = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset mem_req", {31'd0, mem_req}, 32'd0);
    check("reset mem_we", {31'd0, mem_we}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_wd", mem_wd, 32'd0);
    check("reset hit_cnt", hit_cnt, 32'd0);
    check("reset miss_cnt", miss_cnt, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    #1;
    check("idle cpu_rd", cpu_rd, 32'd0);

    // Cold load miss with ack 3 cycles after request, then a hit.
    push_req(1'b0, 32'h100, 32'h0);
    rd_q.push_back(32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF, sc);
    check("t1 miss stall cycles", sc, 32'd4);
    rd_q.push_back(32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'h0, sc);
    check("t1 hit stall cycles", sc, 32'd0);
    check("t1 hit_cnt", hit_cnt, 32'd1);
    check("t1 miss_cnt", miss_cnt, 32'd1);

    // Store hit updates line and writes through.
    push_req(1'b1, 32'h100, 32'h12345678);
    access(1'b0, 1'b1, 32'h100, 32'h12345678, 2, 32'h0, sc);
    check("t2 store stall cycles", sc, 32'd3);
    rd_q.push_back(32'h12345678);
    access(1'b1, 1'b0, 32'h103, 32'h0, 0, 32'h0, sc);
    check("t2 load hit stall", sc, 32'd0);
    check("t2 hit_cnt", hit_cnt, 32'd2);

    // Conflict misses on set 0, minimum-latency ack.
    push_req(1'b0, 32'h120, 32'h0);
    rd_q.push_back(32'hAAAA0120);
    access(1'b1, 1'b0, 32'h120, 32'h0, 0, 32'hAAAA0120, sc);
    check("t3 min miss cost", sc, 32'd1);
    push_req(1'b0, 32'h100, 32'h0);
    rd_q.push_back(32'h12345678);
    access(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'h12345678, sc);
    push_req(1'b0, 32'h120, 32'h0);
    rd_q.push_back(32'hAAAA0120);
    access(1'b1, 1'b0, 32'h120, 32'h0, 2, 32'hAAAA0120, sc);
    check("t3 miss_cnt", miss_cnt, 32'd4);
    rd_q.push_back(32'hAAAA0120);
    access(1'b1, 1'b0, 32'h120, 32'h0, 0, 32'h0, sc);
    check("t3 hit_cnt", hit_cnt, 32'd3);

    // Cold store does not allocate and leaves the resident line intact.
    push_req(1'b1, 32'h200, 32'hCAFEF00D);
    access(1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 1, 32'h0, sc);
    rd_q.push_back(32'hAAAA0120);
    access(1'b1, 1'b0, 32'h120, 32'h0, 0, 32'h0, sc);
    check("t4 resident hit", hit_cnt, 32'd4);
    push_req(1'b0, 32'h200, 32'h0);
    rd_q.push_back(32'hCAFEF00D);
    access(1'b1, 1'b0, 32'h200, 32'h0, 0, 32'hCAFEF00D, sc);
    check("t4 no-allocate miss", miss_cnt, 32'd5);

    // Both re and we high is a store.
    push_req(1'b1, 32'h140, 32'h55AA55AA);
    access(1'b1, 1'b1, 32'h140, 32'h55AA55AA, 0, 32'h0, sc);
    check("t6 store cost", sc, 32'd1);
    check("t6 miss_cnt", miss_cnt, 32'd5);
    check("t6 hit_cnt", hit_cnt, 32'd4);

    // Cache 0x100 again, then reset in the middle of a refill.
    push_req(1'b0, 32'h100, 32'h0);
    rd_q.push_back(32'h12345678);
    access(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'h12345678, sc);
    rd_q.push_back(32'h12345678);
    access(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'h0, sc);
    check("t5 pre-reset hit", hit_cnt, 32'd5);
    push_req(1'b0, 32'h104, 32'h0);
    ack_dly = 100;
    @(posedge clk);
    #1;
    cpu_addr = 32'h104;
    cpu_re   = 1'b1;
    @(negedge clk);
    check("t5 miss stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    check("t5 mem_req before reset", {31'd0, mem_req}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("t5 mem_req in reset", {31'd0, mem_req}, 32'd0);
    check("t5 stall in reset", {31'd0, stall}, 32'd0);
    check("t5 miss_cnt in reset", miss_cnt, 32'd0);
    @(posedge clk);
    #1;
    cpu_re = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    push_req(1'b0, 32'h100, 32'h0);
    rd_q.push_back(32'h12345678);
    access(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'h12345678, sc);
    check("t5 post-reset miss stall", sc, 32'd1);
    check("t5 post-reset miss_cnt", miss_cnt, 32'd1);
    check("t5 post-reset hit_cnt", hit_cnt, 32'd0);

    repeat (2) @(negedge clk);
    check("idle cpu_rd end", cpu_rd, 32'd0);
    check("load queue drained", rd_q.size(), 32'd0);
    check("req queue drained", req_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
